// File: rtl/reorder_buffer_pkg.sv
// Shared core types: ROB and reservation-station rows.
// Package p is imported by the ROB and the dispatch/RS units.
package p;
  localparam int ROB_DEPTH = 16;
  localparam int ROB_IDX_W = 4;
  localparam int PREG_W    = 6;
  localparam int AREG_W    = 5;
  localparam int XLEN      = 32;

  typedef struct packed {
    logic              v;
    logic              done;
    logic [AREG_W-1:0] rd;
    logic [PREG_W-1:0] pd;
    logic [PREG_W-1:0] old_pd;
    logic [XLEN-1:0]   pc;
  } rob_row;

  typedef struct packed {
    logic                 v;
    logic [3:0]           op;
    logic                 rdy1;
    logic [PREG_W-1:0]    ps1;
    logic                 rdy2;
    logic [PREG_W-1:0]    ps2;
    logic [PREG_W-1:0]    pd;
    logic [ROB_IDX_W-1:0] rob_index;
  } rs_row;
endpackage

// File: rtl/reorder_buffer_retire_sel.sv
// rob_retire_sel: picks 0, 1 or 2 retirable entries starting at head.
// Ports: head/next v+done bits in; sel_1/sel_2 and retire count out.
module rob_retire_sel (
  input  logic       head_v,
  input  logic       head_done,
  input  logic       next_v,
  input  logic       next_done,
  output logic       sel_1,
  output logic       sel_2,
  output logic [1:0] n_ret
);
  always_comb begin
    sel_1 = head_v & head_done;
    // head+1 may only go out alongside head
    sel_2 = sel_1 & next_v & next_done;
    n_ret = {1'b0, sel_1} + {1'b0, sel_2};
  end
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: 16-entry circular ROB, dual allocate/retire, NUM_CMPL
// completion ports. Optional flush input when ROB_FLUSH_EN is defined.
module reorder_buffer
  import p::*;
#(
  parameter  int DEPTH    = ROB_DEPTH,
  parameter  int NUM_CMPL = 3,
  localparam int IDX_W    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
`ifdef ROB_FLUSH_EN
  input  logic                      flush,
`endif
  input  logic                      alloc_valid_1,
  input  logic                      alloc_valid_2,
  input  logic [AREG_W-1:0]         alloc_rd_1,
  input  logic [AREG_W-1:0]         alloc_rd_2,
  input  logic [PREG_W-1:0]         alloc_pd_1,
  input  logic [PREG_W-1:0]         alloc_pd_2,
  input  logic [PREG_W-1:0]         alloc_old_pd_1,
  input  logic [PREG_W-1:0]         alloc_old_pd_2,
  input  logic [XLEN-1:0]           alloc_pc_1,
  input  logic [XLEN-1:0]           alloc_pc_2,
  output logic                      alloc_ready,
  output logic [IDX_W-1:0]          alloc_idx_1,
  output logic [IDX_W-1:0]          alloc_idx_2,
  input  logic [NUM_CMPL-1:0]       cmpl_valid,
  input  logic [NUM_CMPL*IDX_W-1:0] cmpl_idx,
  output logic                      ret_valid_1,
  output logic                      ret_valid_2,
  output logic [AREG_W-1:0]         ret_rd_1,
  output logic [AREG_W-1:0]         ret_rd_2,
  output logic [PREG_W-1:0]         ret_pd_1,
  output logic [PREG_W-1:0]         ret_pd_2,
  output logic                      ret_free_valid_1,
  output logic                      ret_free_valid_2,
  output logic [PREG_W-1:0]         ret_old_pd_1,
  output logic [PREG_W-1:0]         ret_old_pd_2,
  output logic [XLEN-1:0]           ret_pc_1,
  output logic [XLEN-1:0]           ret_pc_2,
  output logic [IDX_W:0]            count,
  output logic                      empty,
  output logic                      full
);
  localparam int CNT_W = IDX_W + 1;

  rob_row           rob_q [DEPTH];
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W-1:0] head_p1;
  logic [IDX_W-1:0] tail_p1;
  logic             a1;
  logic             a2;
  logic [1:0]       n_alloc;
  logic [1:0]       n_ret;
  logic             sel_1;
  logic             sel_2;
  logic [CNT_W-1:0] count_nxt;
  logic             do_flush;
  rob_row           head_row;
  rob_row           next_row;

`ifdef ROB_FLUSH_EN
  assign do_flush = flush;
`else
  assign do_flush = 1'b0;
`endif

  assign head_p1     = head + IDX_W'(1);
  assign tail_p1     = tail + IDX_W'(1);
  assign alloc_idx_1 = tail;
  assign alloc_idx_2 = tail_p1;

  // ready needs two free slots, judged on the pre-edge count only
  assign alloc_ready = count <= CNT_W'(DEPTH - 2);
  assign a1          = alloc_valid_1 & alloc_ready;
  assign a2          = a1 & alloc_valid_2;
  assign n_alloc     = {1'b0, a1} + {1'b0, a2};

  assign head_row = rob_q[head];
  assign next_row = rob_q[head_p1];

  rob_retire_sel u_sel (
    .head_v    (head_row.v),
    .head_done (head_row.done),
    .next_v    (next_row.v),
    .next_done (next_row.done),
    .sel_1     (sel_1),
    .sel_2     (sel_2),
    .n_ret     (n_ret)
  );

  assign count_nxt = count + CNT_W'(n_alloc) - CNT_W'(n_ret);
  assign empty     = count == '0;
  assign full      = count == CNT_W'(DEPTH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) rob_q[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (do_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        rob_q[i].v    <= 1'b0;
        rob_q[i].done <= 1'b0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int k = 0; k < NUM_CMPL; k++) begin
        if (cmpl_valid[k] && rob_q[cmpl_idx[k*IDX_W +: IDX_W]].v)
          rob_q[cmpl_idx[k*IDX_W +: IDX_W]].done <= 1'b1;
      end
      // retire after completion so a retiring entry ends up cleared
      if (sel_1) begin
        rob_q[head].v    <= 1'b0;
        rob_q[head].done <= 1'b0;
      end
      if (sel_2) begin
        rob_q[head_p1].v    <= 1'b0;
        rob_q[head_p1].done <= 1'b0;
      end
      if (a1)
        rob_q[tail] <= '{v: 1'b1, done: 1'b0,
                         rd: alloc_rd_1, pd: alloc_pd_1,
                         old_pd: alloc_old_pd_1, pc: alloc_pc_1};
      if (a2)
        rob_q[tail_p1] <= '{v: 1'b1, done: 1'b0,
                            rd: alloc_rd_2, pd: alloc_pd_2,
                            old_pd: alloc_old_pd_2, pc: alloc_pc_2};
      head  <= head + IDX_W'(n_ret);
      tail  <= tail + IDX_W'(n_alloc);
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || do_flush) begin
      ret_valid_1      <= 1'b0;
      ret_valid_2      <= 1'b0;
      ret_free_valid_1 <= 1'b0;
      ret_free_valid_2 <= 1'b0;
      ret_rd_1         <= '0;
      ret_rd_2         <= '0;
      ret_pd_1         <= '0;
      ret_pd_2         <= '0;
      ret_old_pd_1     <= '0;
      ret_old_pd_2     <= '0;
      ret_pc_1         <= '0;
      ret_pc_2         <= '0;
    end else begin
      ret_valid_1      <= sel_1;
      ret_valid_2      <= sel_2;
      // x0 has no real mapping, so nothing goes back to the pool
      ret_free_valid_1 <= sel_1 && head_row.rd != '0;
      ret_free_valid_2 <= sel_2 && next_row.rd != '0;
      ret_rd_1         <= sel_1 ? head_row.rd     : '0;
      ret_rd_2         <= sel_2 ? next_row.rd     : '0;
      ret_pd_1         <= sel_1 ? head_row.pd     : '0;
      ret_pd_2         <= sel_2 ? next_row.pd     : '0;
      ret_old_pd_1     <= sel_1 ? head_row.old_pd : '0;
      ret_old_pd_2     <= sel_2 ? next_row.old_pd : '0;
      ret_pc_1         <= sel_1 ? head_row.pc     : '0;
      ret_pc_2         <= sel_2 ? next_row.pc     : '0;
    end
  end
endmodule
